reg_pipe_sclr: RTL and testbench

Parametrised elastic pipeline register: DEPTH stages of MAX_WIDTH-bit registers, each with its own valid bit, and a valid/ready handshake at both ends. It generalises the single enable/sync-clear register to a multi-stage buffer that collapses bubbles, holds data under backpressure and supports a global freeze (en) and a flush (sclr). It sits between datapath units that need fixed-minimum latency with flow control.

---
 rtl/reg_pkg.sv | 18 +
 rtl/reg_pipe_sclr_pipe_stage.sv | 33 +++
 rtl/reg_pipe_sclr.sv | 99 +++++++++
 tb/tb_reg_pipe_sclr.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_pkg.sv
// Shared helpers for parametrised register blocks: ceiling log2 and the
// width of a counter that must hold values 0..depth.
package reg_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 32'sd0;
        while ((32'sd1 << r) < n) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

    function automatic int cnt_width(input int depth);
        return clog2(depth + 32'sd1);
    endfunction

endpackage

// File: rtl/reg_pipe_sclr_pipe_stage.sv
// One elastic pipeline stage: a valid bit plus data word, cleared by reset
// or flush, loaded on demand, and emptied (valid only) when drained.
module pipe_stage #(
    parameter int MAX_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 load,
    input  logic                 drop,
    input  logic [MAX_WIDTH-1:0] d_in,
    output logic                 v,
    output logic [MAX_WIDTH-1:0] d
);

    // Load takes precedence over drop so a stage that drains and refills stays valid.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            v <= 1'b0;
            d <= {MAX_WIDTH{1'b0}};
        end else if (load) begin
            v <= 1'b1;
            d <= d_in;
        end else if (drop) begin
            v <= 1'b0;
            d <= d;
        end else begin
            v <= v;
            d <= d;
        end
    end

endmodule

// File: rtl/reg_pipe_sclr.sv
// Elastic DEPTH-stage pipeline register with valid/ready at both ends,
// bubble collapsing, global freeze (en) and synchronous flush (sclr).
module reg_pipe_sclr
    import reg_pkg::*;
#(
    parameter  int MAX_WIDTH = 8,
    parameter  int DEPTH     = 4,
    localparam int CNT_W     = cnt_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 sclr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MAX_WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [MAX_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]     count
);

    logic [DEPTH-1:0]     v_s;
    logic [DEPTH-1:0]     adv_s;
    logic [DEPTH-1:0]     load_s;
    logic [MAX_WIDTH-1:0] d_s        [DEPTH];
    logic [MAX_WIDTH-1:0] stage_in_s [DEPTH];
    logic                 go_s;
    logic                 in_ready_s;
    logic                 out_valid_s;
    logic                 in_xfer_s;
    logic                 out_xfer_s;
    logic [CNT_W-1:0]     cnt_r;

    // Advance chain, walked from the output end back toward the input.
    always_comb begin
        logic carry_s;
        go_s    = en & ~sclr & ~rst;
        adv_s   = {DEPTH{1'b0}};
        carry_s = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (i == DEPTH - 1) begin
                adv_s[i] = go_s & v_s[i] & carry_s;
            end else begin
                adv_s[i] = go_s & v_s[i] & (~v_s[i+1] | carry_s);
            end
            carry_s = adv_s[i];
        end
        in_ready_s  = go_s & (~v_s[0] | adv_s[0]);
        out_valid_s = v_s[DEPTH-1] & en & ~sclr;
        in_xfer_s   = in_valid & in_ready_s;
        out_xfer_s  = out_valid_s & out_ready;
    end

    // Per-stage load enables and data sources.
    always_comb begin
        load_s        = {DEPTH{1'b0}};
        load_s[0]     = in_xfer_s;
        stage_in_s[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            load_s[i]     = adv_s[i-1];
            stage_in_s[i] = d_s[i-1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        pipe_stage #(
            .MAX_WIDTH(MAX_WIDTH)
        ) u_stage (
            .clk  (clk),
            .rst  (rst),
            .clr  (sclr),
            .load (load_s[g]),
            .drop (adv_s[g]),
            .d_in (stage_in_s[g]),
            .v    (v_s[g]),
            .d    (d_s[g])
        );
    end

    // Occupancy counter tracks popcount(v) incrementally.
    always_ff @(posedge clk) begin
        if (rst || sclr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (in_xfer_s && !out_xfer_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else if (out_xfer_s && !in_xfer_s) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_data  = d_s[DEPTH-1];
    assign count     = cnt_r;

endmodule

// File: tb/tb_reg_pipe_sclr.sv
// Directed bench for reg_pipe_sclr at DEPTH=4 and DEPTH=1 sharing one stimulus,
// with per-instance scoreboards of accepted items.
module tb_reg_pipe_sclr;

    logic       clk = 1'b0;
    logic       rst, en, sclr, in_valid, out_ready;
    logic [7:0] in_data;
    logic       in_ready4, out_valid4, in_ready1, out_valid1;
    logic [7:0] out_data4, out_data1;
    logic [2:0] count4;
    logic [0:0] count1;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] q4[$];
    logic [7:0] q1[$];
    int         k;
    logic       acc;

    always #5 clk = ~clk;

    reg_pipe_sclr #(.MAX_WIDTH(8), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .sclr(sclr),
        .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .count(count4)
    );

    reg_pipe_sclr #(.MAX_WIDTH(8), .DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .sclr(sclr),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .count(count1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, score transfers, then update models after the edge.
    task automatic cyc();
        logic       xi4, xo4, xi1, xo1, clr;
        logic [7:0] din;
        @(negedge clk);
        xi4 = in_valid & in_ready4;
        xo4 = out_valid4 & out_ready;
        xi1 = in_valid & in_ready1;
        xo1 = out_valid1 & out_ready;
        din = in_data;
        clr = rst | sclr;
        if (xo4 === 1'b1) begin
            check("sb4_nonempty", 32'(q4.size() != 0), 32'd1);
            if (q4.size() != 0) check("sb4_data", 32'(out_data4), 32'(q4[0]));
        end
        if (xo1 === 1'b1) begin
            check("sb1_nonempty", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) check("sb1_data", 32'(out_data1), 32'(q1[0]));
        end
        if (!en || sclr || rst) begin
            check("gate_in_ready4", 32'(in_ready4), 32'd0);
            check("gate_in_ready1", 32'(in_ready1), 32'd0);
        end
        if (!en || sclr) begin
            check("gate_out_valid4", 32'(out_valid4), 32'd0);
            check("gate_out_valid1", 32'(out_valid1), 32'd0);
        end
        @(posedge clk);
        #1;
        if (clr) begin
            q4.delete();
            q1.delete();
        end else begin
            if (xo4 === 1'b1 && q4.size() != 0) void'(q4.pop_front());
            if (xi4 === 1'b1) q4.push_back(din);
            if (xo1 === 1'b1 && q1.size() != 0) void'(q1.pop_front());
            if (xi1 === 1'b1) q1.push_back(din);
        end
        check("count4", 32'(count4), 32'(q4.size()));
        check("count1", 32'(count1), 32'(q1.size()));
    endtask

    // Push n consecutive items into an empty DEPTH=4 pipe with the output stalled.
    task automatic fill(input logic [7:0] base, input int n);
        out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + 8'(i);
            cyc();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; sclr = 1'b0; in_valid = 1'b0;
        out_ready = 1'b1; in_data = 8'h00;
        repeat (2) cyc();
        check("rst_out_valid4", 32'(out_valid4), 32'd0);
        check("rst_out_data4", 32'(out_data4), 32'd0);
        check("rst_count4", 32'(count4), 32'd0);
        rst = 1'b0;
        cyc();

        // Stream three items into an empty pipe.
        in_valid = 1'b1; in_data = 8'hFF;
        cyc();
        check("d1_latency_valid", 32'(out_valid1), 32'd1);
        check("d1_latency_data", 32'(out_data1), 32'hFF);
        in_data = 8'h14; cyc();
        in_data = 8'h0F; cyc();
        in_valid = 1'b0;
        check("stream_count_peak", 32'(count4), 32'd3);
        check("stream_not_yet", 32'(out_valid4), 32'd0);
        cyc();
        check("stream_first_valid", 32'(out_valid4), 32'd1);
        check("stream_first_data", 32'(out_data4), 32'hFF);
        repeat (5) cyc();

        // Backpressure: five offered, four accepted, then drain.
        out_ready = 1'b0;
        #1;
        k = 1;
        repeat (6) begin
            if (k <= 5) begin
                in_valid = 1'b1;
                in_data  = 8'(k);
            end
            acc = in_ready4;
            cyc();
            if (acc) k++;
        end
        check("bp_accepts", 32'(k), 32'd5);
        check("bp_full_count", 32'(count4), 32'd4);
        check("bp_in_ready", 32'(in_ready4), 32'd0);
        check("bp_head", 32'(out_data4), 32'h01);
        out_ready = 1'b1;
        #1;
        check("bp_drain_in_ready", 32'(in_ready4), 32'd1);
        cyc();
        in_valid = 1'b0;
        repeat (6) cyc();
        check("bp_empty", 32'(count4), 32'd0);

        // Full pipe with simultaneous accept and emit.
        fill(8'h21, 4);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
        #1;
        check("full_in_ready", 32'(in_ready4), 32'd1);
        cyc();
        in_valid = 1'b0;
        check("full_count_same", 32'(count4), 32'd4);
        repeat (3) cyc();
        check("full_aa_valid", 32'(out_valid4), 32'd1);
        check("full_aa_data", 32'(out_data4), 32'hAA);
        repeat (5) cyc();

        // Flush mid-stream.
        fill(8'h31, 3);
        check("sclr_pre_count", 32'(count4), 32'd3);
        sclr = 1'b1; in_valid = 1'b1; in_data = 8'h14; out_ready = 1'b1;
        #1;
        check("sclr_in_ready", 32'(in_ready4), 32'd0);
        check("sclr_out_valid", 32'(out_valid4), 32'd0);
        cyc();
        sclr = 1'b0; in_valid = 1'b0;
        check("sclr_count", 32'(count4), 32'd0);
        check("sclr_data", 32'(out_data4), 32'd0);
        check("sclr_valid", 32'(out_valid4), 32'd0);
        repeat (5) cyc();

        // Freeze with two items collapsed to the output end.
        fill(8'h51, 2);
        repeat (3) cyc();
        check("frz_pre_data", 32'(out_data4), 32'h51);
        check("frz_pre_valid", 32'(out_valid4), 32'd1);
        en = 1'b0; out_ready = 1'b1;
        repeat (3) begin
            cyc();
            check("frz_count", 32'(count4), 32'd2);
            check("frz_data", 32'(out_data4), 32'h51);
        end
        en = 1'b1;
        repeat (4) cyc();
        check("frz_drained", 32'(count4), 32'd0);

        // Reset wins over flush, freeze and input on a full pipe.
        fill(8'h61, 4);
        check("rp_full", 32'(count4), 32'd4);
        rst = 1'b1; sclr = 1'b1; en = 1'b0; in_valid = 1'b1; in_data = 8'hAA;
        cyc();
        rst = 1'b0; sclr = 1'b0; en = 1'b1; in_valid = 1'b0;
        check("rp_count4", 32'(count4), 32'd0);
        check("rp_valid4", 32'(out_valid4), 32'd0);
        check("rp_data4", 32'(out_data4), 32'd0);
        check("rp_count1", 32'(count1), 32'd0);
        check("rp_valid1", 32'(out_valid1), 32'd0);
        check("rp_data1", 32'(out_data1), 32'd0);

        // DEPTH=1 full-throughput pass-through.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h71 + 8'(i);
            #1;
            check("d1_in_ready", 32'(in_ready1), 32'd1);
            cyc();
            check("d1_pass_valid", 32'(out_valid1), 32'd1);
            check("d1_pass_data", 32'(out_data1), 32'(8'h71 + 8'(i)));
        end
        in_valid = 1'b0;
        repeat (6) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
